// File: rtl/bus_move_sequencer.sv
// Sequences one register-to-register move over the shared bus: source drives, destination latches, bus released.
// Optional post-increment of the source register is enabled by defining BUS_SEQ_POSTINC_EN.
module bus_move_sequencer #(
    parameter int NUM_REGS  = 8,
    parameter int SEL_WIDTH = 3
) (
    input  logic                 CLOCK,
    input  logic                 RESET,
    // Handshake: a request transfers on a rising edge where REQ_VALID && REQ_READY;
    // the upstream stage holds SRC_SEL/DST_SEL/REQ_VALID stable until then.
    input  logic                 REQ_VALID,
    output logic                 REQ_READY,
    input  logic [SEL_WIDTH-1:0] SRC_SEL,
    input  logic [SEL_WIDTH-1:0] DST_SEL,
`ifdef BUS_SEQ_POSTINC_EN
    input  logic                 POSTINC,
`endif
    output logic [NUM_REGS-1:0]  REG_ENABLE,
    output logic [NUM_REGS-1:0]  REG_RW,
    output logic [NUM_REGS-1:0]  REG_COUNT,
    output logic                 DONE,
    output logic                 ERR,
    output logic [1:0]           STATE_DBG
);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        DRIVE   = 2'd1,
        LATCH   = 2'd2,
        RELEASE = 2'd3
    } state_t;

    state_t                state, state_nxt;
    logic [SEL_WIDTH-1:0]  src_q, src_nxt;
    logic [SEL_WIDTH-1:0]  dst_q, dst_nxt;
    logic [NUM_REGS-1:0]   en_q, en_nxt;
    logic [NUM_REGS-1:0]   rw_q, rw_nxt;
    logic                  done_q, done_nxt;
    logic                  err_q, err_nxt;
    logic [NUM_REGS-1:0]   src_oh, dst_oh;
    logic                  req_bad;

    function automatic logic [NUM_REGS-1:0] decode(input logic [SEL_WIDTH-1:0] sel);
        logic [NUM_REGS-1:0] oh;
        oh = '0;
        for (int i = 0; i < NUM_REGS; i++) begin
            if (sel == SEL_WIDTH'(i)) oh[i] = 1'b1;
        end
        return oh;
    endfunction

    assign src_oh  = decode(src_q);
    assign dst_oh  = decode(dst_q);
    assign req_bad = (SRC_SEL == DST_SEL)
                   || (32'(SRC_SEL) >= 32'(NUM_REGS))
                   || (32'(DST_SEL) >= 32'(NUM_REGS));

`ifdef BUS_SEQ_POSTINC_EN
    logic                  postinc_q, postinc_nxt;
    logic [NUM_REGS-1:0]   cnt_q, cnt_nxt;
`endif

    // Strobes are registered: each state loads the strobe pattern of the state it moves into.
    always_comb begin
        state_nxt = state;
        src_nxt   = src_q;
        dst_nxt   = dst_q;
        en_nxt    = '0;
        rw_nxt    = '1;
        done_nxt  = 1'b0;
        err_nxt   = 1'b0;
`ifdef BUS_SEQ_POSTINC_EN
        postinc_nxt = postinc_q;
        cnt_nxt     = '0;
`endif
        case (state)
            IDLE: begin
                if (REQ_VALID) begin
                    if (req_bad) begin
                        err_nxt = 1'b1;
                    end else begin
                        src_nxt   = SRC_SEL;
                        dst_nxt   = DST_SEL;
                        en_nxt    = decode(SRC_SEL);
                        state_nxt = DRIVE;
`ifdef BUS_SEQ_POSTINC_EN
                        postinc_nxt = POSTINC;
`endif
                    end
                end
            end
            DRIVE: begin
                en_nxt    = src_oh | dst_oh;
                rw_nxt    = ~dst_oh;
                state_nxt = LATCH;
            end
            LATCH: begin
                done_nxt  = 1'b1;
                state_nxt = RELEASE;
`ifdef BUS_SEQ_POSTINC_EN
                if (postinc_q) cnt_nxt = src_oh;
`endif
            end
            RELEASE: begin
                state_nxt = IDLE;
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    always_ff @(posedge CLOCK or posedge RESET) begin
        if (RESET) begin
            state  <= IDLE;
            src_q  <= '0;
            dst_q  <= '0;
            en_q   <= '0;
            rw_q   <= '1;
            done_q <= 1'b0;
            err_q  <= 1'b0;
        end else begin
            state  <= state_nxt;
            src_q  <= src_nxt;
            dst_q  <= dst_nxt;
            en_q   <= en_nxt;
            rw_q   <= rw_nxt;
            done_q <= done_nxt;
            err_q  <= err_nxt;
        end
    end

`ifdef BUS_SEQ_POSTINC_EN
    always_ff @(posedge CLOCK or posedge RESET) begin
        if (RESET) begin
            postinc_q <= 1'b0;
            cnt_q     <= '0;
        end else begin
            postinc_q <= postinc_nxt;
            cnt_q     <= cnt_nxt;
        end
    end
    assign REG_COUNT = cnt_q;
`else
    assign REG_COUNT = '0;
`endif

    assign REQ_READY  = (state == IDLE);
    assign REG_ENABLE = en_q;
    assign REG_RW     = rw_q;
    assign DONE       = done_q;
    assign ERR        = err_q;
    assign STATE_DBG  = state;

endmodule

// File: tb/tb_bus_move_sequencer.sv
// Directed bench for bus_move_sequencer with a small bus-register-file model driven by the DUT strobes.
// Define BUS_SEQ_POSTINC_EN to also exercise the post-increment path.
module tb_bus_move_sequencer;
    localparam int N  = 8;
    localparam int SW = 4;

    logic          CLOCK = 1'b0;
    logic          RESET = 1'b0;
    logic          REQ_VALID = 1'b0;
    logic [SW-1:0] SRC_SEL = '0;
    logic [SW-1:0] DST_SEL = '0;
`ifdef BUS_SEQ_POSTINC_EN
    logic          POSTINC = 1'b0;
`endif
    logic          REQ_READY, DONE, ERR;
    logic [N-1:0]  REG_ENABLE, REG_RW, REG_COUNT;
    logic [1:0]    STATE_DBG;

    int            tests_run = 0;
    int            tests_failed = 0;
    logic [15:0]   regs [N];
    logic [15:0]   exp_q [$];
    int            cyc = 0;
    int            acc_cyc [$];

    always #5 CLOCK = ~CLOCK;

    bus_move_sequencer #(.NUM_REGS(N), .SEL_WIDTH(SW)) dut (
        .CLOCK      (CLOCK),
        .RESET      (RESET),
        .REQ_VALID  (REQ_VALID),
        .REQ_READY  (REQ_READY),
        .SRC_SEL    (SRC_SEL),
        .DST_SEL    (DST_SEL),
`ifdef BUS_SEQ_POSTINC_EN
        .POSTINC    (POSTINC),
`endif
        .REG_ENABLE (REG_ENABLE),
        .REG_RW     (REG_RW),
        .REG_COUNT  (REG_COUNT),
        .DONE       (DONE),
        .ERR        (ERR),
        .STATE_DBG  (STATE_DBG)
    );

    function automatic logic [15:0] init_val(input int i);
        if (i == 0) return 16'h00FF;
        if (i == 2) return 16'h1234;
        return 16'hA000 + 16'(i);
    endfunction

    // Register-file model: the enabled writer drives the bus, enabled readers capture it at the edge.
    always @(posedge CLOCK) begin
        logic [15:0] bus;
        bus = '0;
        for (int i = 0; i < N; i++)
            if (REG_ENABLE[i] && REG_RW[i]) bus = regs[i];
        for (int i = 0; i < N; i++) begin
            if (RESET) regs[i] <= init_val(i);
            else if (REG_ENABLE[i] && !REG_RW[i]) regs[i] <= bus;
            else if (REG_COUNT[i] && REG_RW[i] && !REG_ENABLE[i]) regs[i] <= regs[i] + 16'd1;
        end
        if (REQ_VALID && REQ_READY) acc_cyc.push_back(cyc);
        cyc <= cyc + 1;
    end

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        tests_run++;
        if (act !== exp) begin
            tests_failed++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
        end
    endtask

    task automatic step();
        int drv;
        @(negedge CLOCK);
        drv = 0;
        for (int i = 0; i < N; i++)
            if (REG_ENABLE[i] && REG_RW[i]) drv++;
        check("single_driver", 32'(drv <= 1), 32'd1);
        check("rw_unselected", 32'((~REG_ENABLE & ~REG_RW) == '0), 32'd1);
    endtask

    task automatic expect_reject(input logic [SW-1:0] s, input logic [SW-1:0] d, input string tag);
        REQ_VALID = 1'b1; SRC_SEL = s; DST_SEL = d;
        step();
        REQ_VALID = 1'b0;
        check({tag, "_err"}, 32'(ERR), 32'd1);
        check({tag, "_en"}, 32'(REG_ENABLE), 32'h00);
        check({tag, "_ready"}, 32'(REQ_READY), 32'd1);
        step();
        check({tag, "_err_clr"}, 32'(ERR), 32'd0);
    endtask

    initial begin
        int seen;
        #2 RESET = 1'b1;
        #1;
        check("rst_en", 32'(REG_ENABLE), 32'h00);
        check("rst_rw", 32'(REG_RW), 32'hFF);
        check("rst_cnt", 32'(REG_COUNT), 32'h00);
        check("rst_ready", 32'(REQ_READY), 32'd1);
        check("rst_done", 32'(DONE), 32'd0);
        check("rst_err", 32'(ERR), 32'd0);
        @(negedge CLOCK);
        RESET = 1'b0;
        step();

        // Basic move r2 -> r5
        REQ_VALID = 1'b1; SRC_SEL = 4'd2; DST_SEL = 4'd5;
        exp_q.push_back(regs[2]);
        step();
        REQ_VALID = 1'b0;
        check("mv_drive_en", 32'(REG_ENABLE), 32'h04);
        check("mv_drive_rw", 32'(REG_RW), 32'hFF);
        check("mv_drive_done", 32'(DONE), 32'd0);
        check("mv_drive_ready", 32'(REQ_READY), 32'd0);
        step();
        check("mv_latch_en", 32'(REG_ENABLE), 32'h24);
        check("mv_latch_rw", 32'(REG_RW), 32'hDF);
        step();
        check("mv_rel_en", 32'(REG_ENABLE), 32'h00);
        check("mv_rel_rw", 32'(REG_RW), 32'hFF);
        check("mv_rel_done", 32'(DONE), 32'd1);
        check("mv_rel_cnt", 32'(REG_COUNT), 32'h00);
        step();
        check("mv_idle_done", 32'(DONE), 32'd0);
        check("mv_idle_ready", 32'(REQ_READY), 32'd1);
        check("mv_r5_q", 32'(regs[5]), 32'(exp_q.pop_front()));
        check("mv_r5", 32'(regs[5]), 32'h1234);

        expect_reject(4'd3, 4'd3, "rej_same");
        expect_reject(4'd9, 4'd1, "rej_src9");
        expect_reject(4'd1, 4'd8, "rej_dst8");

        // Back-to-back: 0 -> 1 then 1 -> 7 with REQ_VALID held
        acc_cyc.delete();
        REQ_VALID = 1'b1; SRC_SEL = 4'd0; DST_SEL = 4'd1;
        exp_q.push_back(regs[0]);
        step();
        SRC_SEL = 4'd1; DST_SEL = 4'd7;
        for (int k = 0; k < 8 && acc_cyc.size() < 2; k++) step();
        REQ_VALID = 1'b0;
        check("b2b_accepts", 32'(acc_cyc.size()), 32'd2);
        if (acc_cyc.size() == 2) check("b2b_spacing", 32'(acc_cyc[1] - acc_cyc[0]), 32'd4);
        seen = 0;
        for (int k = 0; k < 6 && seen == 0; k++) begin
            step();
            if (DONE) seen = 1;
        end
        check("b2b_done_seen", 32'(seen), 32'd1);
        step();
        check("b2b_r7_q", 32'(regs[7]), 32'(exp_q.pop_front()));
        check("b2b_r7", 32'(regs[7]), 32'h00FF);
        check("b2b_r1", 32'(regs[1]), 32'h00FF);

        // Reset while in LATCH
        REQ_VALID = 1'b1; SRC_SEL = 4'd3; DST_SEL = 4'd6;
        step();
        REQ_VALID = 1'b0;
        step();
        check("rl_latch_en", 32'(REG_ENABLE), 32'h48);
        #2 RESET = 1'b1;
        #1;
        check("rl_en", 32'(REG_ENABLE), 32'h00);
        check("rl_rw", 32'(REG_RW), 32'hFF);
        check("rl_ready", 32'(REQ_READY), 32'd1);
        @(negedge CLOCK);
        RESET = 1'b0;
        seen = 0;
        for (int k = 0; k < 5; k++) begin
            step();
            if (DONE) seen++;
        end
        check("rl_no_done", 32'(seen), 32'd0);
        check("rl_ready_after", 32'(REQ_READY), 32'd1);

`ifdef BUS_SEQ_POSTINC_EN
        REQ_VALID = 1'b1; SRC_SEL = 4'd0; DST_SEL = 4'd4; POSTINC = 1'b1;
        step();
        REQ_VALID = 1'b0; POSTINC = 1'b0;
        check("pi_drive_cnt", 32'(REG_COUNT), 32'h00);
        step();
        check("pi_latch_cnt", 32'(REG_COUNT), 32'h00);
        step();
        check("pi_rel_cnt", 32'(REG_COUNT), 32'h01);
        check("pi_rel_done", 32'(DONE), 32'd1);
        check("pi_rel_en", 32'(REG_ENABLE), 32'h00);
        step();
        check("pi_idle_cnt", 32'(REG_COUNT), 32'h00);
        check("pi_r4", 32'(regs[4]), 32'h00FF);
        check("pi_r0", 32'(regs[0]), 32'h0100);
`endif

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

endmodule

// File: doc/bus_move_sequencer.md
Name: bus_move_sequencer

Overview:
- Control stage directly upstream of the bank of bidirectional bus registers. It drives their per-register ENABLE, RW and COUNT strobes.
- Accepts one register-to-register move request at a time (source index, destination index) over a valid/ready handshake. It sequences the shared data bus so the source drives, the destination latches, then the bus is released.
- Sits between the instruction decoder and the register file.

Parameters:
- NUM_REGS, 8, number of bus registers controlled (2..16)
- SEL_WIDTH, 3, width of register index; must satisfy 2**SEL_WIDTH >= NUM_REGS

Ports:
- CLOCK  input  1  system clock, rising edge
- RESET  input  1  asynchronous, active-high reset
- REQ_VALID  input  1  move request present
- REQ_READY  output  1  sequencer can accept request (IDLE only)
- SRC_SEL  input  SEL_WIDTH  source register index, sampled on accept
- DST_SEL  input  SEL_WIDTH  destination register index, sampled on accept
- REG_ENABLE  output  NUM_REGS  per-register bus ENABLE
- REG_RW  output  NUM_REGS  per-register RW (0 = read from bus, 1 = write to bus)
- REG_COUNT  output  NUM_REGS  per-register COUNT strobe
- DONE  output  1  one-cycle pulse, move completed
- ERR  output  1  one-cycle pulse, request rejected

Behaviour:
- Reset:
  - Asynchronous reset; the state machine goes to IDLE.
  - REG_ENABLE = 0, REG_RW = all 1s, REG_COUNT = 0, DONE = 0, ERR = 0, REQ_READY = 1.
- Outputs: all are registered, except REQ_READY, which is decoded from the state (1 only in IDLE).
- Accept: a request is accepted on a rising edge where REQ_VALID & REQ_READY. SRC_SEL and DST_SEL are captured into internal registers at that edge.
- Rejection:
  - A request is rejected when SRC_SEL == DST_SEL or either index is >= NUM_REGS.
  - On rejection: ERR pulses high for one cycle, the state stays IDLE, and no strobes are asserted.
- States:
  - IDLE: accept a valid request -> DRIVE.
  - DRIVE (1 cycle):
    - REG_ENABLE[src] = 1, REG_RW[src] = 1; all other enables 0.
    - The source drives DATA after this edge.
    - -> LATCH.
  - LATCH (1 cycle):
    - Source strobes held (REG_ENABLE[src] = 1, REG_RW[src] = 1).
    - REG_ENABLE[dst] = 1, REG_RW[dst] = 0; the destination captures DATA at the closing edge.
    - -> RELEASE.
  - RELEASE (1 cycle):
    - All REG_ENABLE = 0, so the source tri-states at the next edge.
    - DONE = 1.
    - -> IDLE.
- Latency: 3 cycles from accept edge to DONE. Back-to-back throughput is one move per 4 cycles, because REQ_READY returns in the IDLE cycle after RELEASE.
- Bus safety rules:
  - At most one register has ENABLE & RW = 1 in any cycle.
  - A register with ENABLE = 1 and RW = 0 is never the source.
  - REG_RW for non-selected registers is always 1.
- Simultaneous events: REQ_VALID while not in IDLE is ignored (REQ_READY = 0); the request must be held by the upstream stage.
- Reset mid-move:
  - All strobes clear immediately (asynchronously).
  - No DONE is issued.
  - The destination is not guaranteed updated.
- Index decode: one-hot from the captured indices. Indices >= NUM_REGS never decode, because they are rejected on accept.

Optional Feature:
- Macro: BUS_SEQ_POSTINC_EN.
- When defined:
  - Request gains an input port POSTINC (1 bit), captured on accept.
  - If POSTINC = 1, the RELEASE cycle asserts REG_COUNT[src] = 1 with REG_RW[src] = 1 and REG_ENABLE[src] = 0, so the source increments after being copied (PC-style fetch).
  - DONE timing is unchanged.
- When undefined: no POSTINC port; REG_COUNT is tied to all 0s.

Test Plan:
- Reset: assert RESET asynchronously mid-cycle -> REG_ENABLE = 0x00, REG_RW = 0xFF, REG_COUNT = 0, REQ_READY = 1, with no clock edge needed.
- Basic move: SRC = 2, DST = 5 with a register model holding r2 = 0x1234 -> REG_ENABLE = 0x04 (cycle 1), then 0x24 with REG_RW = 0xDF (cycle 2), then 0x00 with DONE = 1 (cycle 3); r5 = 0x1234 afterwards.
- Error: SRC = DST = 3 -> ERR pulses 1 cycle, no REG_ENABLE bit set, REQ_READY stays 1. Repeat with SRC = 9, NUM_REGS = 8 -> ERR.
- Back-to-back: REQ_VALID held high with requests 0->1 then 1->7 -> second accept occurs 4 cycles after the first; r7 ends equal to original r0.
- Reset during LATCH: strobes drop to 0 immediately; after release, REQ_READY = 1 and no DONE pulse is seen.
- BUS_SEQ_POSTINC_EN build: SRC = 0 (0x00FF), DST = 4, POSTINC = 1 -> r4 = 0x00FF, r0 = 0x0100, REG_COUNT = 0x01 only in the DONE cycle.
